// File: rtl/decstage_pipe.sv
// decstage_pipe: decode stage with register file, immediate generation, load-use hazard and ID/EX register.
// Optional macro WB_BYPASS_EN forwards same-cycle write-back data to the operand reads instead of stalling.
module decstage_pipe #(
  parameter int DATA_W = 32,
  parameter int REG_CNT = 32,
  parameter int IMM_W = 16,
  localparam int AW = $clog2(REG_CNT)
) (
  input  logic              Clk,
  input  logic              Rst,
  input  logic [31:0]       Instr,
  input  logic              Instr_valid,
  input  logic              Stall_in,
  input  logic              Flush,
  input  logic              WB_WrEn,
  input  logic [AW-1:0]     WB_Awr,
  input  logic [DATA_W-1:0] WB_Data,
  output logic              Id_ready,
  output logic              Hazard_stall,
  output logic              Ex_valid,
  output logic [5:0]        Ex_opcode,
  output logic [DATA_W-1:0] Ex_RF_A,
  output logic [DATA_W-1:0] Ex_RF_B,
  output logic [DATA_W-1:0] Ex_Immed,
  output logic [AW-1:0]     Ex_Awr
);
  localparam logic [5:0] OP_R    = 6'b100000;
  localparam logic [5:0] OP_LB   = 6'b000011;
  localparam logic [5:0] OP_LW   = 6'b001111;
  localparam logic [5:0] OP_SB   = 6'b000111;
  localparam logic [5:0] OP_SW   = 6'b011111;
  localparam logic [5:0] OP_B    = 6'b111111;
  localparam logic [5:0] OP_BEQ  = 6'b000000;
  localparam logic [5:0] OP_BNE  = 6'b000001;
  localparam logic [5:0] OP_LI   = 6'b111000;
  localparam logic [5:0] OP_ADDI = 6'b110000;
  localparam logic [5:0] OP_LUI  = 6'b111001;
  logic [DATA_W-1:0] r_rf [REG_CNT];
  logic              r_ex_valid;
  logic [5:0]        r_ex_op;
  logic [DATA_W-1:0] r_ex_a, r_ex_b, r_ex_imm;
  logic [AW-1:0]     r_ex_awr;
  logic [5:0]        w_op;
  logic [AW-1:0]     w_rs, w_rd, w_rt, w_baddr;
  logic [IMM_W-1:0]  w_imm;
  logic [DATA_W-1:0] w_sext, w_zext, w_imm_val, w_rf_a, w_rf_b, w_ex_b;
  logic              w_is_r, w_is_load, w_is_store, w_is_br, w_uses_b, w_imm_sx;
  logic              w_ld_haz, w_wb_haz, w_wb_act;
  assign w_op    = Instr[31:26];
  assign w_rs    = Instr[21 +: AW];
  assign w_rd    = Instr[16 +: AW];
  assign w_rt    = Instr[11 +: AW];
  assign w_imm   = Instr[IMM_W-1:0];
  assign w_is_r     = w_op == OP_R;
  assign w_is_load  = w_op == OP_LB || w_op == OP_LW;
  assign w_is_store = w_op == OP_SB || w_op == OP_SW;
  assign w_is_br    = w_op == OP_B || w_op == OP_BEQ || w_op == OP_BNE;
  assign w_uses_b   = w_is_r || w_is_store || w_is_br;
  assign w_imm_sx   = w_is_load || w_is_store || w_op == OP_LI || w_op == OP_ADDI;
  assign w_baddr = w_is_r ? w_rt : w_rd;
  assign w_sext  = DATA_W'($signed(w_imm));
  assign w_zext  = DATA_W'(w_imm);
  assign w_imm_val = w_is_br ? w_sext << 2 :
                     w_op == OP_LUI ? w_zext << 16 :
                     w_imm_sx ? w_sext : w_zext;
  assign w_wb_act = WB_WrEn && WB_Awr != '0;
`ifdef WB_BYPASS_EN
  assign w_rf_a = w_rs == '0 ? '0 : (w_wb_act && WB_Awr == w_rs) ? WB_Data : r_rf[w_rs];
  assign w_rf_b = w_baddr == '0 ? '0 : (w_wb_act && WB_Awr == w_baddr) ? WB_Data : r_rf[w_baddr];
  assign w_wb_haz = 1'b0;
`else
  assign w_rf_a = w_rs == '0 ? '0 : r_rf[w_rs];
  assign w_rf_b = w_baddr == '0 ? '0 : r_rf[w_baddr];
  // without forwarding, a same-cycle write must land in the RF before it is read
  assign w_wb_haz = w_wb_act && Instr_valid && (WB_Awr == w_rs || (w_uses_b && WB_Awr == w_baddr));
`endif
  assign w_ex_b = w_op == OP_SB ? DATA_W'(w_rf_b[7:0]) : w_rf_b;
  assign w_ld_haz = r_ex_valid && (r_ex_op == OP_LB || r_ex_op == OP_LW) && r_ex_awr != '0 &&
                    Instr_valid && (r_ex_awr == w_rs || (w_uses_b && r_ex_awr == w_baddr));
  assign Hazard_stall = (w_ld_haz || w_wb_haz) && !Stall_in && !Flush;
  assign Id_ready     = !Stall_in && !Hazard_stall && !Rst;
  always_ff @(posedge Clk) begin
    if (Rst)
      for (int i = 0; i < REG_CNT; i++) r_rf[i] <= '0;
    else if (w_wb_act)
      r_rf[WB_Awr] <= WB_Data;
  end
  always_ff @(posedge Clk) begin
    if (Rst) begin
      r_ex_valid <= 1'b0;
      r_ex_op    <= '0;
      r_ex_a     <= '0;
      r_ex_b     <= '0;
      r_ex_imm   <= '0;
      r_ex_awr   <= '0;
    end else if (Flush) begin
      r_ex_valid <= 1'b0;
    end else if (!Stall_in) begin
      if (Hazard_stall) begin
        r_ex_valid <= 1'b0;
      end else begin
        r_ex_valid <= Instr_valid;
        r_ex_op    <= w_op;
        r_ex_a     <= w_rf_a;
        r_ex_b     <= w_ex_b;
        r_ex_imm   <= w_imm_val;
        r_ex_awr   <= w_rd;
      end
    end
  end
  assign Ex_valid  = r_ex_valid;
  assign Ex_opcode = r_ex_op;
  assign Ex_RF_A   = r_ex_a;
  assign Ex_RF_B   = r_ex_b;
  assign Ex_Immed  = r_ex_imm;
  assign Ex_Awr    = r_ex_awr;
endmodule

// File: tb/tb_decstage_pipe.sv
// tb_decstage_pipe: directed test-plan steps plus random traffic checked against a behavioural model.
module tb_decstage_pipe;
  logic        Clk = 1'b0;
  logic        Rst = 1'b1;
  logic [31:0] Instr = '0;
  logic        Instr_valid = 1'b0, Stall_in = 1'b0, Flush = 1'b0, WB_WrEn = 1'b0;
  logic [4:0]  WB_Awr = '0;
  logic [31:0] WB_Data = '0;
  logic        Id_ready, Hazard_stall, Ex_valid;
  logic [5:0]  Ex_opcode;
  logic [31:0] Ex_RF_A, Ex_RF_B, Ex_Immed;
  logic [4:0]  Ex_Awr;
  decstage_pipe dut (
    .Clk(Clk), .Rst(Rst), .Instr(Instr), .Instr_valid(Instr_valid), .Stall_in(Stall_in),
    .Flush(Flush), .WB_WrEn(WB_WrEn), .WB_Awr(WB_Awr), .WB_Data(WB_Data), .Id_ready(Id_ready),
    .Hazard_stall(Hazard_stall), .Ex_valid(Ex_valid), .Ex_opcode(Ex_opcode), .Ex_RF_A(Ex_RF_A),
    .Ex_RF_B(Ex_RF_B), .Ex_Immed(Ex_Immed), .Ex_Awr(Ex_Awr)
  );
  always #5 Clk = ~Clk;
  int checks = 0, errors = 0;
  logic [31:0] m_rf [32];
  logic        m_valid, m_known, m_rdy;
  logic [5:0]  m_op;
  logic [31:0] m_a, m_b, m_imm;
  logic [4:0]  m_awr;
  logic        last_hs, last_rdy;
`ifdef WB_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask
  function automatic logic [31:0] mk(input logic [5:0] op, input int rs, input int rd, input logic [15:0] im);
    logic [4:0] s, d;
    s = 5'(rs);
    d = 5'(rd);
    return {op, s, d, im};
  endfunction
  function automatic logic [31:0] ref_imm(input logic [5:0] op, input logic [15:0] im);
    int s;
    s = int'($signed(im));
    if (op inside {6'b111000, 6'b110000, 6'b000011, 6'b000111, 6'b001111, 6'b011111}) return 32'(s);
    if (op inside {6'b111111, 6'b000000, 6'b000001}) return 32'(s * 4);
    if (op == 6'b111001) return 32'(im) * 32'h10000;
    return 32'(im);
  endfunction
  function automatic logic [31:0] mread(input logic [4:0] a, input logic we, input logic [4:0] wa, input logic [31:0] wd);
    if (a == 0) return 32'h0;
    if (BYP && we && wa == a) return wd;
    return m_rf[a];
  endfunction
  task automatic cyc(input logic rst, input logic [31:0] ins, input logic iv, input logic st, input logic fl,
                     input logic we, input logic [4:0] wa, input logic [31:0] wd);
    logic [5:0]  op;
    logic [4:0]  rs, rd, ba;
    logic [31:0] a, b;
    logic        ub, haz, ehs;
    Rst = rst; Instr = ins; Instr_valid = iv; Stall_in = st; Flush = fl;
    WB_WrEn = we; WB_Awr = wa; WB_Data = wd;
    #1;
    op = ins[31:26]; rs = ins[25:21]; rd = ins[20:16];
    ba = (op == 6'b100000) ? ins[15:11] : rd;
    ub = op inside {6'b100000, 6'b000111, 6'b011111, 6'b111111, 6'b000000, 6'b000001};
    a = mread(rs, we, wa, wd);
    b = mread(ba, we, wa, wd);
    haz = m_valid && (m_op == 6'b000011 || m_op == 6'b001111) && m_awr != 0 && iv &&
          (m_awr == rs || (ub && m_awr == ba));
    if (!BYP && we && wa != 0 && iv && (wa == rs || (ub && wa == ba))) haz = 1'b1;
    ehs = haz && !st && !fl;
    m_rdy = !st && !ehs && !rst;
    last_hs = Hazard_stall; last_rdy = Id_ready;
    chk("hazard_stall", 32'(Hazard_stall), 32'(ehs));
    chk("id_ready", 32'(Id_ready), 32'(m_rdy));
    @(posedge Clk);
    if (rst) begin
      foreach (m_rf[i]) m_rf[i] = '0;
      m_valid = 0; m_known = 1; m_op = 0; m_a = 0; m_b = 0; m_imm = 0; m_awr = 0;
    end else begin
      if (we && wa != 0) m_rf[wa] = wd;
      if (fl || (!st && ehs)) begin
        m_valid = 0; m_known = 0;
      end else if (!st) begin
        m_valid = iv; m_known = 1; m_op = op; m_a = a;
        m_b = (op == 6'b000111) ? {24'h0, b[7:0]} : b;
        m_imm = ref_imm(op, ins[15:0]); m_awr = rd;
      end
    end
    @(negedge Clk);
    chk("ex_valid", 32'(Ex_valid), 32'(m_valid));
    if (m_known) begin
      chk("ex_opcode", 32'(Ex_opcode), 32'(m_op));
      chk("ex_rf_a", Ex_RF_A, m_a);
      chk("ex_rf_b", Ex_RF_B, m_b);
      chk("ex_immed", Ex_Immed, m_imm);
      chk("ex_awr", 32'(Ex_Awr), 32'(m_awr));
    end
  endtask
  initial begin
    logic [5:0]  ops [14];
    logic [31:0] ins;
    logic        iv;
    logic [15:0] im;
    ops = '{6'b100000, 6'b000011, 6'b001111, 6'b000111, 6'b011111, 6'b111111, 6'b000000,
            6'b000001, 6'b111000, 6'b110000, 6'b110010, 6'b110011, 6'b111001, 6'b010101};
    foreach (m_rf[i]) m_rf[i] = '0;
    m_valid = 0; m_known = 0; m_rdy = 0; m_op = 0; m_a = 0; m_b = 0; m_imm = 0; m_awr = 0;
    @(negedge Clk);
    cyc(1, 0, 0, 0, 0, 0, 0, 0);
    cyc(1, 0, 0, 0, 0, 1, 5, 32'h5555);
    chk("rst_ex_valid", 32'(Ex_valid), 0);
    chk("rst_ex_rf_a", Ex_RF_A, 0);
    cyc(0, 0, 0, 0, 0, 1, 5, 32'h0000_1234);
    cyc(0, mk(6'b110000, 5, 6, 16'hFFFE), 1, 0, 0, 0, 0, 0);
    chk("t1_valid", 32'(Ex_valid), 1);
    chk("t1_rf_a", Ex_RF_A, 32'h0000_1234);
    chk("t1_imm", Ex_Immed, 32'hFFFF_FFFE);
    chk("t1_awr", 32'(Ex_Awr), 6);
    cyc(0, mk(6'b110010, 0, 1, 16'h8001), 1, 0, 0, 0, 0, 0);
    chk("t2_ori", Ex_Immed, 32'h0000_8001);
    cyc(0, mk(6'b000000, 0, 1, 16'hFFFF), 1, 0, 0, 0, 0, 0);
    chk("t2_beq", Ex_Immed, 32'hFFFF_FFFC);
    cyc(0, mk(6'b111001, 0, 1, 16'h00AB), 1, 0, 0, 0, 0, 0);
    chk("t2_lui", Ex_Immed, 32'h00AB_0000);
    cyc(0, mk(6'b000011, 0, 3, 16'h0004), 1, 0, 0, 0, 0, 0);
    cyc(0, mk(6'b100000, 3, 4, 16'h0000), 1, 0, 0, 0, 0, 0);
    chk("t3_haz", 32'(last_hs), 1);
    chk("t3_rdy", 32'(last_rdy), 0);
    chk("t3_bubble", 32'(Ex_valid), 0);
    cyc(0, mk(6'b100000, 3, 4, 16'h0000), 1, 0, 0, 0, 0, 0);
    chk("t3_retry_haz", 32'(last_hs), 0);
    chk("t3_issue", 32'(Ex_valid), 1);
    chk("t3_awr", 32'(Ex_Awr), 4);
    cyc(0, mk(6'b110010, 5, 2, 16'h00F0), 1, 0, 0, 0, 0, 0);
    for (int k = 0; k < 3; k++) begin
      cyc(0, mk(6'b110000, 1, 9, 16'(k)), 1, 1, 0, 0, 0, 0);
      chk("t4_hold_a", Ex_RF_A, 32'h0000_1234);
      chk("t4_hold_imm", Ex_Immed, 32'h0000_00F0);
      chk("t4_hold_valid", 32'(Ex_valid), 1);
    end
    cyc(0, mk(6'b110000, 1, 9, 16'h0), 1, 1, 1, 0, 0, 0);
    chk("t4_flush", 32'(Ex_valid), 0);
    cyc(0, mk(6'b110000, 7, 8, 16'h0001), 1, 0, 0, 1, 7, 32'hDEAD_BEEF);
    chk("t5_haz", 32'(last_hs), BYP ? 0 : 1);
    if (!BYP) cyc(0, mk(6'b110000, 7, 8, 16'h0001), 1, 0, 0, 0, 0, 0);
    chk("t5_rf_a", Ex_RF_A, 32'hDEAD_BEEF);
    chk("t5_valid", 32'(Ex_valid), 1);
    cyc(0, 0, 0, 0, 0, 1, 9, 32'h1122_3344);
    cyc(0, mk(6'b000111, 0, 9, 16'h0010), 1, 0, 0, 0, 0, 0);
    chk("t6_sb", Ex_RF_B, 32'h0000_0044);
    cyc(0, mk(6'b110000, 0, 0, 16'h0000), 1, 0, 0, 1, 0, 32'hFFFF_FFFF);
    chk("t6_r0_same", Ex_RF_A, 0);
    cyc(0, mk(6'b011111, 0, 0, 16'h0000), 1, 0, 0, 0, 0, 0);
    chk("t6_r0_a", Ex_RF_A, 0);
    chk("t6_r0_b", Ex_RF_B, 0);
    ins = 0; iv = 0;
    for (int n = 0; n < 600; n++) begin
      if (m_rdy || n == 0) begin
        im = 16'($urandom);
        im[15:11] = 5'($urandom_range(0, 7));
        ins = mk(($urandom_range(0, 7) == 0) ? 6'($urandom) : ops[$urandom_range(0, 13)],
                 $urandom_range(0, 7), $urandom_range(0, 7), im);
        iv = $urandom_range(0, 9) != 0;
      end
      cyc($urandom_range(0, 63) == 0, ins, iv, $urandom_range(0, 6) == 0, $urandom_range(0, 9) == 0,
          $urandom_range(0, 2) == 0, 5'($urandom_range(0, 7)), $urandom);
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/decstage_pipe.md
Name: decstage_pipe

Overview:
- Parametrised successor of the single-cycle decode stage.
- Decodes `Instr`, reads an internal register file, generates the immediate and registers the result into an ID/EX pipeline register.
- Detects load-use hazards on its own in-flight EX entry and inserts bubbles; supports downstream stall and branch flush.
- Sits between the fetch/IF-ID register and the execute stage; WB stage writes back through dedicated ports.

Parameters:
- DATA_W, 32, datapath and register width (>=16).
- REG_CNT, 32, number of registers (power of 2, <=32); `AW = $clog2(REG_CNT)`.
- IMM_W, 16, immediate field width in `Instr[IMM_W-1:0]`.

Ports:
- Clk  in  1  clock; all state on rising edge.
- Rst  in  1  synchronous reset, active-high.
- Instr  in  32  instruction; opcode=`[31:26]`, rs=`[25:21]`, rd=`[20:16]`, rt=`[15:11]`.
- Instr_valid  in  1  `Instr` is a real instruction.
- Stall_in  in  1  execute stage cannot accept; hold ID/EX.
- Flush  in  1  kill instruction entering ID/EX (taken branch).
- WB_WrEn  in  1  write-back enable.
- WB_Awr  in  AW  write-back register address.
- WB_Data  in  DATA_W  write-back data.
- Id_ready  out  1  decode accepts `Instr` this cycle; upstream must hold `Instr` while 0.
- Hazard_stall  out  1  load-use bubble inserted this cycle.
- Ex_valid  out  1  ID/EX entry valid.
- Ex_opcode  out  6  registered opcode.
- Ex_RF_A  out  DATA_W  registered rs operand.
- Ex_RF_B  out  DATA_W  registered second operand.
- Ex_Immed  out  DATA_W  registered immediate.
- Ex_Awr  out  AW  registered destination (rd).

Behaviour:
Register file
- Register 0 reads 0; writes to it are ignored.
- Writes happen at the clock edge when `WB_WrEn` is high, regardless of stall or flush.
- `Rst` clears all registers.

Second read address
- rt when opcode==`100000` (R-type).
- Otherwise rd (stores and branches read rd).

Immediate (opcodes are binary literals)
- Sign-extend: `111000`, `110000`, `000011`, `000111`, `001111`, `011111`.
- Zero-fill: `110010`, `110011`.
- Sign-extend then shift left 2: `111111`, `000000`, `000001`.
- Shift left 16, zero low bits: `111001`.
- All other opcodes: zero-fill.

Store-byte operand
- Opcode `000111`: `Ex_RF_B = {zeros, RF_B[7:0]}`.

Load-use hazard (combinational)
- `haz = Ex_valid & (Ex_opcode==000011 | Ex_opcode==001111) & Ex_Awr!=0 & Instr_valid & (Ex_Awr==rs | (uses_B & Ex_Awr==B_addr))`.
- `uses_B` is true for R-type, stores and branches.
- `Hazard_stall = haz & ~Stall_in & ~Flush`.
- `Id_ready = ~Stall_in & ~Hazard_stall & ~Rst`.

ID/EX update priority, per clock
1. `Rst`: all `Ex_*` outputs go to 0, including `Ex_valid`.
2. `Flush`: `Ex_valid<=0`; other `Ex_*` are don't-care. Flush overrides `Stall_in`.
3. `Stall_in`: all `Ex_*` hold.
4. `Hazard_stall`: `Ex_valid<=0` (bubble); `Instr` is held upstream and retried next cycle.
5. Otherwise: load decoded values; `Ex_valid<=Instr_valid`.

Timing and boundaries
- Latency: `Instr` to `Ex_*` is 1 cycle.
- Hazard adds exactly 1 bubble cycle, because the load then leaves the EX entry.
- `Rst` mid-stall clears the pipeline; WB writes in the reset cycle are discarded.

Optional Feature:
WB_BYPASS_EN
- Defined: a read address equal to `WB_Awr` (nonzero) with `WB_WrEn` high returns `WB_Data` in the same cycle (write-before-read).
- Undefined: the read returns the old contents. Hazard logic additionally asserts `Hazard_stall` when `WB_WrEn & WB_Awr!=0` matches rs or the used B address, giving one bubble before the value is read from the RF.

Test Plan:
1. Reset, then WB writes r5=`0x0000_1234`; `Instr` addi (opcode `110000`, rs=5, rd=6, imm=`0xFFFE`) -> next cycle `Ex_valid`=1, `Ex_RF_A`=`0x1234`, `Ex_Immed`=`0xFFFF_FFFE`, `Ex_Awr`=6.
2. Immediate coverage:
   - ori imm `0x8001` -> `0x0000_8001`.
   - beq imm `0xFFFF` -> `0xFFFF_FFFC`.
   - lui imm `0x00AB` -> `0x00AB_0000`.
3. lw into r3, then add rs=3 -> `Hazard_stall`=1 and `Id_ready`=0 for 1 cycle, one bubble (`Ex_valid`=0), then add issues; `Ex_valid`=1 the following cycle.
4. `Stall_in`=1 for 3 cycles with an entry loaded -> `Ex_*` unchanged; `Flush` asserted together with `Stall_in` -> `Ex_valid`=0 next cycle.
5. WB writes r7=`0xDEAD_BEEF` while decoding a read of r7:
   - With WB_BYPASS_EN: `Ex_RF_A`=`0xDEADBEEF`, no stall.
   - Without: 1-cycle `Hazard_stall`, then `0xDEADBEEF`.
6. sb with r9=`0x1122_3344` -> `Ex_RF_B`=`0x0000_0044`; WB write to r0 -> reads of r0 stay 0.
